// File: rtl/display_video_generate_dmd.sv
// Triggered single-frame video timing generator for the DMD display path.
// Optional slope/flip offset enabled by DMD_SLOPE_CORRECT_EN.
module display_video_generate_dmd #(
    parameter int H_ACTIVE   = 1920,
    parameter int H_SYNC     = 44,
    parameter int H_BP       = 148,
    parameter int H_FP       = 88,
    parameter int V_ACTIVE   = 1080,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 36,
    parameter int V_FP       = 4,
    parameter int SLOPE_STEP = 72
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_start_trig,
    input  logic        frame_all_zeros,
    input  logic        dmd_correct_15_pixles_slope,
    input  logic        dmd_flip_left_and_right,
    output logic        hsync_o_with_camera_format,
    output logic        vsync_o_with_camera_format,
    output logic        de_o,
    output logic        hsync_o_with_hdmi_format,
    output logic        vsync_o_with_hdmi_format,
    output logic        de_o_with_hdmi_format,
    output logic        de_o_first_offset_line,
    output logic [23:0] display_vedio_left_offset,
    output logic        frame_busy,
    output logic        de_with_all_zeros,
    output logic [10:0] frame_count
);

    localparam logic [11:0] H_LAST = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [11:0] HS_END = 12'(H_SYNC);
    localparam logic [11:0] HA_BEG = 12'(H_SYNC + H_BP);
    localparam logic [11:0] HA_END = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_LAST = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [10:0] VS_END = 11'(V_SYNC);
    localparam logic [10:0] VA_BEG = 11'(V_SYNC + V_BP);
    localparam logic [10:0] VA_END = 11'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q, state_n;
    logic [11:0] h_q, h_n;
    logic [10:0] v_q, v_n;
    logic        zeros_q, zeros_n;
    logic [10:0] cnt_q, cnt_n;

    logic        busy_n;
    logic        hact_n;
    logic        vact_n;
    logic        vact_q;
    logic        de_n;
    logic [3:0]  off_n;

    assign vact_q = (v_q >= VA_BEG) && (v_q < VA_END);

    always_comb begin
        state_n = state_q;
        h_n     = h_q;
        v_n     = v_q;
        zeros_n = zeros_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start_trig) begin
                    state_n = BUSY;
                    h_n     = '0;
                    v_n     = '0;
                    zeros_n = frame_all_zeros;
                end
            end
            BUSY: begin
                if (h_q == H_LAST) begin
                    h_n = '0;
                    if (v_q == V_LAST) begin
                        state_n = IDLE;
                        v_n     = '0;
                        cnt_n   = cnt_q + 11'd1;
                    end else begin
                        v_n = v_q + 11'd1;
                    end
                end else begin
                    h_n = h_q + 12'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_n = (state_n == BUSY);
    assign hact_n = (h_n >= HA_BEG) && (h_n < HA_END);
    assign vact_n = (v_n >= VA_BEG) && (v_n < VA_END);
    assign de_n   = busy_n && hact_n && vact_n;

`ifdef DMD_SLOPE_CORRECT_EN
    localparam logic [10:0] STEP_LAST = 11'(SLOPE_STEP - 1);

    logic        slope_q, slope_n;
    logic        flip_q, flip_n;
    logic [10:0] step_q, step_n;
    logic [3:0]  base_q, base_n;

    // base tracks min(y / SLOPE_STEP, 15) by counting finished active lines
    always_comb begin
        slope_n = slope_q;
        flip_n  = flip_q;
        step_n  = step_q;
        base_n  = base_q;
        if (state_q == IDLE) begin
            if (frame_start_trig) begin
                slope_n = dmd_correct_15_pixles_slope;
                flip_n  = dmd_flip_left_and_right;
                step_n  = '0;
                base_n  = '0;
            end
        end else if ((h_q == H_LAST) && vact_q) begin
            if (step_q == STEP_LAST) begin
                step_n = '0;
                if (base_q != 4'd15) begin
                    base_n = base_q + 4'd1;
                end
            end else begin
                step_n = step_q + 11'd1;
            end
        end
    end

    always_comb begin
        off_n = 4'd0;
        if (busy_n && vact_n && slope_n) begin
            off_n = flip_n ? (4'd15 - base_n) : base_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slope_q <= 1'b0;
            flip_q  <= 1'b0;
            step_q  <= '0;
            base_q  <= '0;
        end else begin
            slope_q <= slope_n;
            flip_q  <= flip_n;
            step_q  <= step_n;
            base_q  <= base_n;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = dmd_correct_15_pixles_slope ^ dmd_flip_left_and_right ^ vact_q;
    assign off_n      = 4'd0;
`endif

    // outputs are built from next-state values so they align with the counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q                    <= IDLE;
            h_q                        <= '0;
            v_q                        <= '0;
            zeros_q                    <= 1'b0;
            cnt_q                      <= '0;
            hsync_o_with_camera_format <= 1'b0;
            vsync_o_with_camera_format <= 1'b1;
            de_o                       <= 1'b0;
            hsync_o_with_hdmi_format   <= 1'b0;
            vsync_o_with_hdmi_format   <= 1'b0;
            de_o_with_hdmi_format      <= 1'b0;
            de_o_first_offset_line     <= 1'b0;
            display_vedio_left_offset  <= '0;
            frame_busy                 <= 1'b0;
            de_with_all_zeros          <= 1'b0;
        end else begin
            state_q                    <= state_n;
            h_q                        <= h_n;
            v_q                        <= v_n;
            zeros_q                    <= zeros_n;
            cnt_q                      <= cnt_n;
            hsync_o_with_camera_format <= de_n;
            vsync_o_with_camera_format <= !busy_n;
            de_o                       <= de_n;
            hsync_o_with_hdmi_format   <= busy_n && (h_n < HS_END);
            vsync_o_with_hdmi_format   <= busy_n && (v_n < VS_END);
            de_o_with_hdmi_format      <= de_n;
            de_o_first_offset_line     <= de_n && (v_n == VA_BEG);
            display_vedio_left_offset  <= {20'd0, off_n};
            frame_busy                 <= busy_n;
            de_with_all_zeros          <= de_n && zeros_n;
        end
    end

    assign frame_count = cnt_q;

endmodule

// File: tb/tb_display_video_generate_dmd.sv
// Randomized bench for display_video_generate_dmd against a per-cycle frame model.
// A second tiny instance exercises the frame counter wrap.
`timescale 1ns/1ps
module tb_display_video_generate_dmd;

    localparam int HS = 3, HB = 4, HA = 10, HF = 2;
    localparam int VS = 2, VB = 3, VA = 50, VF = 2;
    localparam int STEP = 3;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int FT2 = 16;
`ifdef DMD_SLOPE_CORRECT_EN
    localparam bit SLOPE_ON = 1'b1;
`else
    localparam bit SLOPE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, trig = 1'b0, zeros = 1'b0, slope = 1'b0, flip = 1'b0;
    logic hs_cam, vs_cam, de, hs_hdmi, vs_hdmi, de_hdmi, de_first;
    logic [23:0] offset;
    logic busy, de_zero;
    logic [10:0] fcount;

    display_video_generate_dmd #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF),
        .SLOPE_STEP(STEP)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .frame_start_trig(trig),
        .frame_all_zeros(zeros),
        .dmd_correct_15_pixles_slope(slope),
        .dmd_flip_left_and_right(flip),
        .hsync_o_with_camera_format(hs_cam),
        .vsync_o_with_camera_format(vs_cam),
        .de_o(de),
        .hsync_o_with_hdmi_format(hs_hdmi),
        .vsync_o_with_hdmi_format(vs_hdmi),
        .de_o_with_hdmi_format(de_hdmi),
        .de_o_first_offset_line(de_first),
        .display_vedio_left_offset(offset),
        .frame_busy(busy),
        .de_with_all_zeros(de_zero),
        .frame_count(fcount)
    );

    logic rst2 = 1'b1, trig2 = 1'b0, zero_in2 = 1'b0;
    logic t_hs_cam, t_vs_cam, t_de, t_hs_hdmi, t_vs_hdmi, t_de_hdmi, t_de_first;
    logic [23:0] t_offset;
    logic busy2, t_de_zero;
    logic [10:0] fcount2;

    display_video_generate_dmd #(
        .H_ACTIVE(1), .H_SYNC(1), .H_BP(1), .H_FP(1),
        .V_ACTIVE(1), .V_SYNC(1), .V_BP(1), .V_FP(1),
        .SLOPE_STEP(1)
    ) u_tiny (
        .clk_i(clk), .rst_i(rst2),
        .frame_start_trig(trig2),
        .frame_all_zeros(zero_in2),
        .dmd_correct_15_pixles_slope(zero_in2),
        .dmd_flip_left_and_right(zero_in2),
        .hsync_o_with_camera_format(t_hs_cam),
        .vsync_o_with_camera_format(t_vs_cam),
        .de_o(t_de),
        .hsync_o_with_hdmi_format(t_hs_hdmi),
        .vsync_o_with_hdmi_format(t_vs_hdmi),
        .de_o_with_hdmi_format(t_de_hdmi),
        .de_o_first_offset_line(t_de_first),
        .display_vedio_left_offset(t_offset),
        .frame_busy(busy2),
        .de_with_all_zeros(t_de_zero),
        .frame_count(fcount2)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit finished = 1'b0;

    task automatic finish_up();
        if (!finished) begin
            finished = 1'b1;
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Frame model: a frame is just a cycle index k while busy
    bit m_busy = 1'b0, m_zeros = 1'b0, m_slope = 1'b0, m_flip = 1'b0;
    int m_k = 0, m_count = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_k <= 0; m_count <= 0;
            m_zeros <= 1'b0; m_slope <= 1'b0; m_flip <= 1'b0;
        end else if (m_busy) begin
            if (m_k == FT - 1) begin
                m_busy  <= 1'b0;
                m_count <= (m_count + 1) % 2048;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (trig) begin
            m_busy <= 1'b1; m_k <= 0;
            m_zeros <= zeros; m_slope <= slope; m_flip <= flip;
        end
    end

    function automatic logic [42:0] model_out();
        int h, v, y, base, off;
        bit hact, vact, d;
        h = m_k % HT;
        v = m_k / HT;
        y = v - (VS + VB);
        hact = m_busy && h >= HS + HB && h < HS + HB + HA;
        vact = m_busy && v >= VS + VB && v < VS + VB + VA;
        d = hact && vact;
        base = (y < 0) ? 0 : y / STEP;
        if (base > 15) base = 15;
        off = 0;
        if (SLOPE_ON && vact && m_slope) off = m_flip ? 15 - base : base;
        return {d, !m_busy, d, m_busy && h < HS, m_busy && v < VS, d,
                d && y == 0, 24'(off), m_busy, d && m_zeros, 11'(m_count)};
    endfunction

    bit t_busy = 1'b0;
    int t_k = 0, t_count = 0, t_done = 0;

    always @(posedge clk) begin
        if (rst2) begin
            t_busy <= 1'b0; t_k <= 0; t_count <= 0;
        end else if (t_busy) begin
            if (t_k == FT2 - 1) begin
                t_busy  <= 1'b0;
                t_count <= (t_count + 1) % 2048;
                t_done  <= t_done + 1;
            end else begin
                t_k <= t_k + 1;
            end
        end else if (trig2) begin
            t_busy <= 1'b1; t_k <= 0;
        end
    end

    always @(negedge clk) begin
        logic [42:0] dv, mv;
        logic [11:0] dv2, mv2;
        if (chk_en && !finished) begin
            dv = {hs_cam, vs_cam, de, hs_hdmi, vs_hdmi, de_hdmi, de_first,
                  offset, busy, de_zero, fcount};
            mv = model_out();
            vectors++;
            if (dv !== mv) begin
                miscompares++;
                $display("FAIL main_cycle t=%0t k=%0d dut=%h model=%h", $time, m_k, dv, mv);
            end
            dv2 = {busy2, fcount2};
            mv2 = {t_busy, 11'(t_count)};
            vectors++;
            if (dv2 !== mv2) begin
                miscompares++;
                $display("FAIL tiny_cycle t=%0t dut=%h model=%h", $time, dv2, mv2);
            end
            if (miscompares >= 40) finish_up();
        end
    end

    // Caller sits at a negedge; returns at the first idle negedge after the frame.
    task automatic run_frame(input bit s, input bit f, input bit z, input int retrig,
                             output int nb, output int nde, output int nz,
                             output int nhs, output int nvs, output int first,
                             output int o0, output int o3, output int o49);
        int k, y;
        trig = 1'b1; zeros = z; slope = s; flip = f;
        @(negedge clk);
        trig = 1'b0;
        zeros = 1'($urandom); slope = 1'($urandom); flip = 1'($urandom);
        nb = 0; nde = 0; nz = 0; nhs = 0; nvs = 0;
        first = -1; o0 = -1; o3 = -1; o49 = -1;
        for (int i = 0; i < FT + 5; i++) begin
            if (!busy) break;
            nb++;
            k = nb - 1;
            y = k / HT - (VS + VB);
            if (de) begin
                nde++;
                if (first < 0) first = k;
                if (y == 0 && o0 < 0) o0 = int'(offset);
                if (y == 3 && o3 < 0) o3 = int'(offset);
                if (y == 49 && o49 < 0) o49 = int'(offset);
            end
            if (de_zero) nz++;
            if (hs_hdmi) nhs++;
            if (vs_hdmi) nvs++;
            trig = (k == retrig) || (k == FT - 1);
            @(negedge clk);
        end
        trig = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b0;
        trig2 = 1'b1;
    end

    initial begin
        int nb, nde, nz, nhs, nvs, first, o0, o3, o49;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_vsync_cam", int'(vs_cam), 1);
        check("reset_de", int'(de), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_count", int'(fcount), 0);
        check("reset_offset", int'(offset), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b1, 1'b0, 1'b0, -1, nb, nde, nz, nhs, nvs, first, o0, o3, o49);
        check("f1_busy_len", nb, 1083);
        check("f1_first_de", first, 102);
        check("f1_de_cycles", nde, 500);
        check("f1_zero_de", nz, 0);
        check("f1_hdmi_hsync", nhs, 171);
        check("f1_hdmi_vsync", nvs, 38);
        check("f1_off_y0", o0, 0);
        check("f1_off_y3", o3, SLOPE_ON ? 1 : 0);
        check("f1_off_y49", o49, SLOPE_ON ? 15 : 0);
        check("f1_count", int'(fcount), 1);

        run_frame(1'b1, 1'b1, 1'b1, 1000, nb, nde, nz, nhs, nvs, first, o0, o3, o49);
        check("f2_busy_len", nb, 1083);
        check("f2_de_cycles", nde, 500);
        check("f2_zero_de", nz, 500);
        check("f2_off_y0", o0, SLOPE_ON ? 15 : 0);
        check("f2_off_y3", o3, SLOPE_ON ? 14 : 0);
        check("f2_off_y49", o49, 0);
        check("f2_count", int'(fcount), 2);

        for (int i = 0; i < 15000; i++) begin
            trig  = ($urandom_range(0, 60) == 0);
            zeros = 1'($urandom);
            slope = 1'($urandom);
            flip  = 1'($urandom);
            rst   = ($urandom_range(0, 3999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        trig = 1'b0;

        for (int i = 0; i < 40000 && t_done < 2048; i++) @(negedge clk);
        check("wrap_frames", t_done, 2048);
        check("wrap_count", int'(fcount2), 0);
        finish_up();
    end

endmodule
